// File: rtl/alu_mdu_seq_if.sv
// Request/response bundle for alu_mdu_seq: valid/ready request side plus
// the registered result outputs.
interface alu_mdu_seq_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [3:0]      aluop;
  logic            out_valid;
  logic [XLEN-1:0] aluout;
  logic            zero;
  logic            busy;

  // Requester side (control unit / execute stage)
  modport master (
    output in_valid, a, b, aluop,
    input  in_ready, out_valid, aluout, zero, busy
  );

  // ALU/MDU side
  modport slave (
    input  in_valid, a, b, aluop,
    output in_ready, out_valid, aluout, zero, busy
  );
endinterface

// File: rtl/alu_mdu_seq.sv
// Multi-cycle ALU/MDU: logic/arith ops in one registered cycle, unsigned
// multiply and divide iterated one bit per cycle behind a valid/ready handshake.
module alu_mdu_seq #(
  parameter int unsigned XLEN   = 64,
  parameter bit          MDU_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  alu_mdu_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(XLEN);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ITER = 1'b1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLT = 4'b0111;

  logic [0:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        mop_q, mop_d;     // aluop[1:0] of the iterative op
  logic [2*XLEN-1:0] acc_q, acc_d;     // {hi, lo}: product or {remainder, quotient}
  logic [XLEN-1:0]   opb_q, opb_d;     // multiplicand / divisor
  logic [XLEN-1:0]   aluout_q, aluout_d;
  logic              zero_q, zero_d;
  logic              out_valid_q, out_valid_d;

  logic              accept;
  logic              is_mdu;
  logic [XLEN-1:0]   single_res;
  logic [XLEN-1:0]   iter_res;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     rem_diff;
  logic [2*XLEN-1:0] mul_step;
  logic [2*XLEN-1:0] div_step;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == ITER);
  assign bus.out_valid = out_valid_q;
  assign bus.aluout    = aluout_q;
  assign bus.zero      = zero_q;

  assign accept = bus.in_valid && (state_q == IDLE);
  // With MDU_EN=0 the MUL/DIV codes fall through to the illegal-op path.
  assign is_mdu = MDU_EN && (bus.aluop[3:2] == 2'b10);

  // Single-cycle op results; illegal codes produce zero
  always_comb begin
    single_res = '0;
    case (bus.aluop)
      OP_AND:  single_res = bus.a & bus.b;
      OP_OR:   single_res = bus.a | bus.b;
      OP_ADD:  single_res = bus.a + bus.b;
      OP_SUB:  single_res = bus.a - bus.b;
      OP_NOR:  single_res = ~(bus.a | bus.b);
      OP_SLT:  single_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: single_res = '0;
    endcase
  end

  // One iteration step of shift-add multiply and restoring divide
  always_comb begin
    add_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_step  = {add_sum, acc_q[XLEN-1:1]};
    rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, opb_q};
    // A borrow out of the trial subtraction means the divisor did not fit: restore.
    div_step  = rem_diff[XLEN] ? {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  // Control FSM and datapath next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mop_d       = mop_q;
    acc_d       = acc_q;
    opb_d       = opb_q;
    aluout_d    = aluout_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    iter_res    = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mdu) begin
            state_d = ITER;
            cnt_d   = '0;
            mop_d   = bus.aluop[1:0];
            opb_d   = bus.b;
            acc_d   = {{XLEN{1'b0}}, bus.a};
          end else begin
            aluout_d    = single_res;
            zero_d      = (single_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      ITER: begin
        acc_d = mop_q[1] ? div_step : mul_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) begin
          // MULHU/REMU live in the upper half, MUL/DIVU in the lower half.
          iter_res    = mop_q[0] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
          state_d     = IDLE;
          cnt_d       = '0;
          aluout_d    = iter_res;
          zero_d      = (iter_res == '0);
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mop_q       <= '0;
      acc_q       <= '0;
      opb_q       <= '0;
      aluout_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mop_q       <= mop_d;
      acc_q       <= acc_d;
      opb_q       <= opb_d;
      aluout_q    <= aluout_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Self-checking bench for alu_mdu_seq: directed cases with literal results,
// then randomized traffic checked every cycle against a behavioural model.
module tb_alu_mdu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  aluop;

  int checks = 0;
  int errors = 0;

  alu_mdu_seq_if #(.XLEN(64)) bus  ();
  alu_mdu_seq_if #(.XLEN(64)) bus0 ();

  assign bus.in_valid  = in_valid;
  assign bus.a         = a;
  assign bus.b         = b;
  assign bus.aluop     = aluop;
  assign bus0.in_valid = in_valid;
  assign bus0.a        = a;
  assign bus0.b        = b;
  assign bus0.aluop    = aluop;

  alu_mdu_seq #(.XLEN(64), .MDU_EN(1'b1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  alu_mdu_seq #(.XLEN(64), .MDU_EN(1'b0)) u_dut_nomdu (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_mdu_op(input logic [3:0] op);
    return (op == 4'd8) || (op == 4'd9) || (op == 4'd10) || (op == 4'd11);
  endfunction

  // Reference results straight from the operation definitions.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] x,
                                        input logic [63:0] y, input bit mdu);
    logic [127:0] p;
    p = {64'd0, x} * {64'd0, y};
    case (op)
      4'd0:    return x & y;
      4'd1:    return x | y;
      4'd2:    return x + y;
      4'd6:    return x - y;
      4'd12:   return ~(x | y);
      4'd7:    return ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      4'd8:    return mdu ? p[63:0] : 64'd0;
      4'd9:    return mdu ? p[127:64] : 64'd0;
      4'd10:   return !mdu ? 64'd0 : (y == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : x / y;
      4'd11:   return !mdu ? 64'd0 : (y == 0) ? x : x % y;
      default: return 64'd0;
    endcase
  endfunction

  // Model state: one outstanding iterative op at most.
  bit          primed = 0;
  bit          m_pend = 0;
  int          m_left = 0;
  logic [63:0] m_pval = '0;
  logic [63:0] m_out  = '0;
  bit          m_valid = 0;
  bit          m_ready = 1;
  logic [63:0] m2_out = '0;
  bit          m2_valid = 0;

  // Compare process: check this cycle's outputs, then advance the model with
  // this cycle's inputs (they are sampled at the coming rising edge).
  initial begin
    bit ready_now;
    forever begin
      @(negedge clk);
      if (primed) begin
        chk("in_ready", bus.in_ready, m_ready);
        chk("busy", bus.busy, !m_ready);
        chk("out_valid", bus.out_valid, m_valid);
        chk("aluout", bus.aluout, m_out);
        chk("zero", bus.zero, m_out == 0);
        chk("nomdu in_ready", bus0.in_ready, 1);
        chk("nomdu out_valid", bus0.out_valid, m2_valid);
        chk("nomdu aluout", bus0.aluout, m2_out);
        chk("nomdu zero", bus0.zero, m2_out == 0);
      end
      if (reset === 1'b1) begin
        m_pend = 0; m_out = '0; m_valid = 0;
        m2_out = '0; m2_valid = 0;
        primed = 1;
      end else if (primed) begin
        m_valid   = 0;
        ready_now = !m_pend;
        if (m_pend) begin
          m_left--;
          if (m_left == 0) begin
            m_out = m_pval; m_valid = 1; m_pend = 0;
          end
        end
        if (ready_now && in_valid) begin
          if (is_mdu_op(aluop)) begin
            m_pend = 1; m_left = 64; m_pval = model(aluop, a, b, 1'b1);
          end else begin
            m_out = model(aluop, a, b, 1'b1); m_valid = 1;
          end
        end
        m2_valid = in_valid;
        if (in_valid) m2_out = model(aluop, a, b, 1'b0);
      end
      m_ready = !m_pend;
    end
  end

  // Issue one op, check literal result, latency and ready-low cycles.
  task automatic do_op(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] exp, input int lat);
    int n;
    int low;
    bit seen;
    n = 0;
    while (!bus.in_ready && n < 200) begin @(posedge clk); #1; n++; end
    aluop = op; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~x; b = ~y;   // operands must already be captured
    @(negedge clk);
    chk("nomdu 1-cycle valid", bus0.out_valid, 1);
    chk("nomdu 1-cycle result", bus0.aluout, is_mdu_op(op) ? 64'd0 : exp);
    n = 1;
    low = bus.in_ready ? 0 : 1;
    seen = bus.out_valid;
    while (!seen && n < 200) begin
      @(negedge clk); n++;
      seen = bus.out_valid;
      if (!bus.in_ready) low++;
    end
    chk("latency", n, lat);
    chk("ready-low cycles", low, lat - 1);
    chk("result", bus.aluout, exp);
    chk("result zero", bus.zero, exp == 0);
    chk("ready in valid cycle", bus.in_ready, 1);
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'($urandom_range(0, 20));
      4:       return {32'd0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [3:0] op_of(input int idx);
    case (idx)
      0: return 4'd0;  1: return 4'd1;  2: return 4'd2;  3: return 4'd6;  4: return 4'd12;
      5: return 4'd7;  6: return 4'd8;  7: return 4'd9;  8: return 4'd10;
      default: return 4'd11;
    endcase
  endfunction

  initial begin
    int n;
    int pulses;
    int idx;
    bit seen;
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; aluop = '0;

    // 1: reset held two cycles
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset aluout", bus.aluout, 0);
    chk("reset zero", bus.zero, 1);
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset out_valid", bus.out_valid, 0);
    @(posedge clk); #1;

    // 2-4: single-cycle and iterative literal cases
    do_op(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1);
    do_op(4'd6, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1);
    do_op(4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1);
    do_op(4'd8, 64'h1_0000_0001, 64'd3, 64'h3_0000_0003, 65);
    do_op(4'd9, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
          64'h4000_0000_0000_0000, 65);
    do_op(4'd10, 64'd100, 64'd7, 64'd14, 65);
    do_op(4'd11, 64'd100, 64'd7, 64'd2, 65);
    do_op(4'd10, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    do_op(4'd11, 64'd9, 64'd0, 64'd9, 65);
    do_op(4'd3, 64'd5, 64'd5, 64'd0, 1);

    // 5: request held through ITER is ignored, then accepted in the valid cycle
    aluop = 4'd10; a = 64'd1000; b = 64'd10; in_valid = 1'b1;
    @(posedge clk); #1;
    aluop = 4'd2; a = 64'd3; b = 64'd4;
    n = 0; seen = 0;
    while (!seen && n < 200) begin @(negedge clk); n++; seen = bus.out_valid; end
    chk("held-req latency", n, 65);
    chk("held-req first result", bus.aluout, 64'd100);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("back-to-back valid", bus.out_valid, 1);
    chk("back-to-back result", bus.aluout, 64'd7);
    @(posedge clk); #1;

    // 6: reset during ITER cycle 30 aborts the op
    aluop = 4'd8; a = 64'h1234_5678; b = 64'h9ABC_DEF0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort in_ready", bus.in_ready, 1);
    chk("abort aluout", bus.aluout, 0);
    chk("abort zero", bus.zero, 1);
    pulses = 0;
    repeat (80) begin
      if (bus.out_valid) pulses++;
      @(negedge clk);
    end
    chk("abort pulses", pulses, 0);
    @(posedge clk); #1;

    // Randomized traffic; the compare process checks every cycle
    repeat (4000) begin
      reset    = ($urandom_range(0, 399) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) begin
        aluop = 4'($urandom_range(0, 15));
      end else begin
        idx = $urandom_range(0, 9);
        if (idx >= 6 && $urandom_range(0, 2) != 0) idx = $urandom_range(0, 5);
        aluop = op_of(idx);
      end
      a = rnd_opnd();
      b = rnd_opnd();
      @(posedge clk); #1;
    end
    reset = 1'b0; in_valid = 1'b0;
    repeat (80) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
